// File: rtl/pin_in_filter.sv
// -----------------------------------------------------------------------------
// pin_in_filter
//
// Debounce and edge-detect filter for asynchronous board input pins. Each pin
// is first brought into the clk_i domain by a two-flop synchronizer. A per-pin
// stability counter then only lets the filtered value follow the synchronized
// value once it has differed for thr consecutive cycles. A 0->1 change of the
// filtered value pulses rise_o and a 1->0 change pulses fall_o, each for one
// cycle. Either edge sets a sticky event bit, and a single interrupt line ORs
// together all enabled event bits.
//
// The threshold is thr = max(filter_cycles_i, 1), so a setting of 0 behaves
// exactly like 1.
//
// Parameters
//   NumPins   number of filtered pins
//   CntWidth  width of the stability counter and of filter_cycles_i
//   ResetVal  reset value of the synchronizers and of pins_o
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous, active-high reset
//   pins_i           raw asynchronous pad inputs
//   filter_cycles_i  stability threshold in cycles (quasi-static, shared)
//   event_clr_i      per-pin single-cycle clear of the sticky event bits
//   irq_en_i         per-pin interrupt enable
//   pins_o           filtered pin values
//   rise_o           one-cycle pulse on a 0->1 change of pins_o
//   fall_o           one-cycle pulse on a 1->0 change of pins_o
//   event_o          sticky per-pin change flags
//   irq_o            OR of (event_o & irq_en_i)
// -----------------------------------------------------------------------------
module pin_in_filter #(
    parameter int unsigned          NumPins  = 8,
    parameter int unsigned          CntWidth = 8,
    parameter logic [NumPins-1:0]   ResetVal = '1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPins-1:0]  pins_i,
    input  logic [CntWidth-1:0] filter_cycles_i,
    input  logic [NumPins-1:0]  event_clr_i,
    input  logic [NumPins-1:0]  irq_en_i,
    output logic [NumPins-1:0]  pins_o,
    output logic [NumPins-1:0]  rise_o,
    output logic [NumPins-1:0]  fall_o,
    output logic [NumPins-1:0]  event_o,
    output logic                irq_o
);

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Only sync2_q is used by the filter logic.
    // -------------------------------------------------------------------------
    logic [NumPins-1:0] sync1_q;
    logic [NumPins-1:0] sync2_q;

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers update together from values sampled before the edge; with
    // blocking assignments sync2_q would see this cycle's sync1_q and the
    // synchronizer would collapse to a single flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= ResetVal;
            sync2_q <= ResetVal;
        end else begin
            sync1_q <= pins_i;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Effective threshold minus one. A setting of 0 is treated as 1, so the
    // comparison value bottoms out at 0 instead of wrapping to all ones.
    // -------------------------------------------------------------------------
    logic [CntWidth-1:0] thr_m1;

    always_comb begin
        if (filter_cycles_i == '0) begin
            thr_m1 = '0;
        end else begin
            thr_m1 = filter_cycles_i - CntWidth'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Per-pin stability counter and filtered value.
    // -------------------------------------------------------------------------
    logic [CntWidth-1:0] cnt_q [NumPins];
    logic [CntWidth-1:0] cnt_d [NumPins];
    logic [NumPins-1:0]  pins_q;
    logic [NumPins-1:0]  pins_d;

    // NOTE: every output of this block receives a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pins_d = pins_q;
        for (int i = 0; i < NumPins; i++) begin
            cnt_d[i] = '0;
        end

        for (int i = 0; i < NumPins; i++) begin
            if (sync2_q[i] == pins_q[i]) begin
                // Input agrees with the filtered value: restart the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_m1) begin
                // Stable for thr cycles. The >= also covers a threshold that
                // was lowered below the running count, which then accepts the
                // new value on the next edge.
                pins_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                // Still counting. cnt_q < thr_m1 here, so this cannot wrap.
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge pulses and sticky events, computed from the next filtered value so
    // that they are registered alongside pins_q and show up in the same cycle
    // as the new pins_o value.
    // -------------------------------------------------------------------------
    logic [NumPins-1:0] rise_q;
    logic [NumPins-1:0] rise_d;
    logic [NumPins-1:0] fall_q;
    logic [NumPins-1:0] fall_d;
    logic [NumPins-1:0] event_q;
    logic [NumPins-1:0] event_d;

    always_comb begin
        rise_d  = pins_d & ~pins_q;
        fall_d  = ~pins_d & pins_q;
        // A new edge overrides a clear in the same cycle.
        event_d = (event_q & ~event_clr_i) | rise_d | fall_d;
    end

    // NOTE: the counter array is small and lives in flops, so it is reset
    // along with the other state. A reset in the middle of a count then
    // discards that count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pins_q  <= ResetVal;
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= '0;
            for (int i = 0; i < NumPins; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pins_q  <= pins_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
            for (int i = 0; i < NumPins; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pins_o  = pins_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;
    assign irq_o   = |(event_q & irq_en_i);

endmodule

// File: tb/tb_pin_in_filter.sv
// -----------------------------------------------------------------------------
// tb_pin_in_filter
//
// Directed bench for pin_in_filter with the default parameters (8 pins,
// 8-bit counter, ResetVal = 8'hFF). A table of per-cycle vectors covers the
// basic thr=1 path, and hand-written sequences cover glitch rejection, a
// lowered threshold, threshold 0, set/clear priority and a reset taken in the
// middle of a count.
// -----------------------------------------------------------------------------
module tb_pin_in_filter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] pins_i;
    logic [7:0] filter_cycles_i;
    logic [7:0] event_clr_i;
    logic [7:0] irq_en_i;
    logic [7:0] pins_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] event_o;
    logic       irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    pin_in_filter #(
        .NumPins  (8),
        .CntWidth (8),
        .ResetVal (8'hFF)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pins_i          (pins_i),
        .filter_cycles_i (filter_cycles_i),
        .event_clr_i     (event_clr_i),
        .irq_en_i        (irq_en_i),
        .pins_o          (pins_o),
        .rise_o          (rise_o),
        .fall_o          (fall_o),
        .event_o         (event_o),
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] pins;
        logic [7:0] clr;
        logic [7:0] en;
        logic [7:0] e_pins;
        logic [7:0] e_rise;
        logic [7:0] e_fall;
        logic [7:0] e_event;
        logic       e_irq;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before inputs change or
    // outputs are sampled.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int fall_cnt;
        int fall_idx;
        int early_low;

        // Hand-computed per-cycle vectors at thr=1. Each row is driven, one
        // edge taken, then the outputs compared.
        tbl[0] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{8'hFE, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{8'hFE, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{8'hFE, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h01, 8'h01, 1'b0};
        tbl[4] = '{8'hFE, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h01, 1'b1};
        tbl[5] = '{8'hFE, 8'h01, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{8'hFF, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{8'hFF, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b0};
        tbl[9] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 1'b0};

        // ---------------- reset state ----------------
        rst_i           = 1'b1;
        pins_i          = 8'hFF;
        filter_cycles_i = 8'd1;
        event_clr_i     = 8'h00;
        irq_en_i        = 8'h00;
        #2;
        tick(); tick(); tick();
        check("reset pins_o",  {24'd0, pins_o},  32'hFF);
        check("reset rise_o",  {24'd0, rise_o},  32'h00);
        check("reset fall_o",  {24'd0, fall_o},  32'h00);
        check("reset event_o", {24'd0, event_o}, 32'h00);
        check("reset irq_o",   {31'd0, irq_o},   32'h0);
        rst_i = 1'b0;

        // ---------------- table: thr=1 step, irq, clear ----------------
        for (int r = 0; r < 10; r++) begin
            pins_i      = tbl[r].pins;
            event_clr_i = tbl[r].clr;
            irq_en_i    = tbl[r].en;
            tick();
            check($sformatf("tbl[%0d] pins_o", r),  {24'd0, pins_o},  {24'd0, tbl[r].e_pins});
            check($sformatf("tbl[%0d] rise_o", r),  {24'd0, rise_o},  {24'd0, tbl[r].e_rise});
            check($sformatf("tbl[%0d] fall_o", r),  {24'd0, fall_o},  {24'd0, tbl[r].e_fall});
            check($sformatf("tbl[%0d] event_o", r), {24'd0, event_o}, {24'd0, tbl[r].e_event});
            check($sformatf("tbl[%0d] irq_o", r),   {31'd0, irq_o},   {31'd0, tbl[r].e_irq});
        end

        // Clear all events before the next sequence.
        event_clr_i = 8'hFF;
        tick();
        event_clr_i = 8'h00;
        check("clear all event_o", {24'd0, event_o}, 32'h00);

        // ---------------- pin 2: irq and set-wins-over-clear ----------------
        pins_i = 8'hFB;
        tick(); tick(); tick();
        check("p2 fall pins_o",  {24'd0, pins_o},  32'hFB);
        check("p2 fall fall_o",  {24'd0, fall_o},  32'h04);
        check("p2 fall event_o", {24'd0, event_o}, 32'h04);
        irq_en_i = 8'h04;
        #1;
        check("p2 irq_o enabled", {31'd0, irq_o}, 32'h1);
        pins_i = 8'hFF;
        tick(); tick();
        event_clr_i = 8'h04;   // coincides with the edge that raises pins_o[2]
        tick();
        check("p2 coinc rise_o",  {24'd0, rise_o},  32'h04);
        check("p2 coinc event_o", {24'd0, event_o}, 32'h04);
        check("p2 coinc irq_o",   {31'd0, irq_o},   32'h1);
        tick();                 // clear alone
        check("p2 clr event_o", {24'd0, event_o}, 32'h00);
        check("p2 clr irq_o",   {31'd0, irq_o},   32'h0);
        check("p2 clr rise_o",  {24'd0, rise_o},  32'h00);
        event_clr_i = 8'h00;
        irq_en_i    = 8'h00;

        // ---------------- pin 3 glitch rejection, thr=4 ----------------
        filter_cycles_i = 8'd4;
        tick(); tick();
        fall_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            pins_i = (k < 3) ? 8'hF7 : 8'hFF;
            tick();
            if (fall_o[3]) fall_cnt++;
        end
        check("glitch3 fall count", fall_cnt, 0);
        check("glitch3 pins_o",     {24'd0, pins_o}, 32'hFF);
        check("glitch3 rise_o",     {24'd0, rise_o}, 32'h00);

        fall_cnt = 0;
        fall_idx = -1;
        for (int k = 0; k < 12; k++) begin
            pins_i = (k < 4) ? 8'hF7 : 8'hFF;
            tick();
            if (fall_o[3]) begin
                fall_cnt++;
                fall_idx = k;
                check("pulse4 pins_o at fall", {24'd0, pins_o}, 32'hF7);
            end
        end
        check("pulse4 fall count", fall_cnt, 1);
        check("pulse4 fall edge",  fall_idx, 5);
        check("pulse4 pins_o end", {24'd0, pins_o}, 32'hFF);

        // ---------------- pin 4: threshold lowered mid-count ----------------
        filter_cycles_i = 8'd200;
        pins_i          = 8'hEF;
        for (int k = 0; k < 102; k++) tick();   // count has reached 100
        check("thr200 pins_o held", {24'd0, pins_o}, 32'hFF);
        filter_cycles_i = 8'd50;
        tick();
        check("thr50 pins_o", {24'd0, pins_o}, 32'hEF);
        check("thr50 fall_o", {24'd0, fall_o}, 32'h10);

        // ---------------- threshold 0 behaves as 1 ----------------
        filter_cycles_i = 8'd0;
        pins_i          = 8'hFF;
        tick(); tick();
        check("thr0 pins_o early", {24'd0, pins_o}, 32'hEF);
        tick();
        check("thr0 pins_o",  {24'd0, pins_o}, 32'hFF);
        check("thr0 rise_o",  {24'd0, rise_o}, 32'h10);

        // ---------------- reset mid-count on pin 3, thr=4 ----------------
        filter_cycles_i = 8'd4;
        event_clr_i     = 8'hFF;
        tick();
        event_clr_i     = 8'h00;
        irq_en_i        = 8'hFF;
        pins_i          = 8'hF7;
        for (int k = 0; k < 5; k++) tick();     // count has reached 3
        rst_i = 1'b1;
        tick();
        check("rstmid pins_o",  {24'd0, pins_o},  32'hFF);
        check("rstmid fall_o",  {24'd0, fall_o},  32'h00);
        check("rstmid event_o", {24'd0, event_o}, 32'h00);
        check("rstmid irq_o",   {31'd0, irq_o},   32'h0);
        rst_i     = 1'b0;
        fall_cnt  = 0;
        fall_idx  = -1;
        early_low = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fall_o[3]) begin
                fall_cnt++;
                fall_idx = k;
            end
            if (k < 5 && pins_o[3] == 1'b0) early_low = 1;
        end
        check("rstmid early low",  early_low, 0);
        check("rstmid fall count", fall_cnt, 1);
        check("rstmid fall edge",  fall_idx, 5);
        check("rstmid pins_o end", {24'd0, pins_o},  32'hF7);
        check("rstmid event_o",    {24'd0, event_o}, 32'h08);
        check("rstmid irq_o end",  {31'd0, irq_o},   32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
